// File: rtl/exec_wb_queue.sv
// Integer execute stage with a DEPTH-entry writeback FIFO; result visible at head one cycle after acceptance.
// Back-pressure: in_ready drops when full (no same-cycle bypass on pop); head held stable while out_ready is low.
module exec_wb_queue #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 4,
  parameter int RDW   = 5,
  localparam int AW   = $clog2(DEPTH),
  localparam int CW   = AW + 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      in_op,
  input  logic [XLEN-1:0] in_rs1,
  input  logic [XLEN-1:0] in_rs2,
  input  logic [RDW-1:0]  in_rd,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_result,
  output logic [RDW-1:0]  out_rd,
  output logic            out_reset_ack,
  output logic            activation,
  output logic [CW-1:0]   count
);

  localparam logic [2:0] OP_ADD    = 3'd0;
  localparam logic [2:0] OP_SUB    = 3'd1;
  localparam logic [2:0] OP_AND    = 3'd2;
  localparam logic [2:0] OP_OR     = 3'd3;
  localparam logic [2:0] OP_XOR    = 3'd4;
  localparam logic [2:0] OP_SLT    = 3'd5;
  localparam logic [2:0] OP_SLTU   = 3'd6;
  localparam logic [2:0] OP_RSTACK = 3'd7;

  logic [XLEN-1:0] mem_result [DEPTH];
  logic [RDW-1:0]  mem_rd     [DEPTH];
  logic            mem_ack    [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic            push;
  logic            pop;
  logic [XLEN-1:0] alu_res;
  logic            alu_ack;

  assign in_ready  = (count < CW'(DEPTH));
  assign out_valid = (count != '0);
  assign push      = in_valid & in_ready & ~flush;
  assign pop       = out_valid & out_ready & ~flush;

  always_comb begin
    alu_res = '0;
    alu_ack = 1'b0;
    case (in_op)
      OP_ADD:    alu_res = in_rs1 + in_rs2;
      OP_SUB:    alu_res = in_rs1 - in_rs2;
      OP_AND:    alu_res = in_rs1 & in_rs2;
      OP_OR:     alu_res = in_rs1 | in_rs2;
      OP_XOR:    alu_res = in_rs1 ^ in_rs2;
      OP_SLT:    alu_res = {{(XLEN-1){1'b0}}, ($signed(in_rs1) < $signed(in_rs2))};
      OP_SLTU:   alu_res = {{(XLEN-1){1'b0}}, (in_rs1 < in_rs2)};
      OP_RSTACK: alu_ack = 1'b1;
      default:   alu_res = '0;
    endcase
  end

  // Storage needs no reset: head outputs are gated by out_valid.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_result[wr_ptr] <= alu_res;
      mem_rd[wr_ptr]     <= in_rd;
      mem_ack[wr_ptr]    <= alu_ack;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      activation <= 1'b0;
    end else begin
      activation <= pop;
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + AW'(1);
        if (pop)  rd_ptr <= rd_ptr + AW'(1);
        if (push && !pop)      count <= count + CW'(1);
        else if (pop && !push) count <= count - CW'(1);
      end
    end
  end

  assign out_result    = out_valid ? mem_result[rd_ptr] : '0;
  assign out_rd        = out_valid ? mem_rd[rd_ptr]     : '0;
  assign out_reset_ack = out_valid ? mem_ack[rd_ptr]    : 1'b0;

endmodule

// File: tb/tb_exec_wb_queue.sv
// Randomised bench for exec_wb_queue against a queue-based reference model.
module tb_exec_wb_queue;
  localparam int XLEN  = 32;
  localparam int DEPTH = 4;
  localparam int RDW   = 5;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [2:0]      in_op = '0;
  logic [XLEN-1:0] in_rs1 = '0;
  logic [XLEN-1:0] in_rs2 = '0;
  logic [RDW-1:0]  in_rd = '0;
  logic            flush = 1'b0;
  logic            out_valid;
  logic            out_ready = 1'b0;
  logic [XLEN-1:0] out_result;
  logic [RDW-1:0]  out_rd;
  logic            out_reset_ack;
  logic            activation;
  logic [2:0]      count;

  int vectors = 0;
  int miscompares = 0;

  // Reference model: plain queues of pending writebacks
  logic [XLEN-1:0] q_res[$];
  logic [RDW-1:0]  q_rd[$];
  logic            q_ack[$];
  logic            m_act = 1'b0;

  exec_wb_queue #(.XLEN(XLEN), .DEPTH(DEPTH), .RDW(RDW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_rd(out_rd), .out_reset_ack(out_reset_ack), .activation(activation), .count(count)
  );

  always #5 clk = ~clk;

  function automatic logic [XLEN:0] ref_op(input logic [2:0] op, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
    longint unsigned ua = a;
    longint unsigned ub = b;
    int sa = int'(a);
    int sb = int'(b);
    logic [XLEN-1:0] r;
    case (op)
      3'd0: r = XLEN'((ua + ub) % 64'h1_0000_0000);
      3'd1: r = XLEN'((ua + 64'h1_0000_0000 - ub) % 64'h1_0000_0000);
      3'd2: r = a & b;
      3'd3: r = a | b;
      3'd4: r = a ^ b;
      3'd5: r = (sa < sb) ? 32'd1 : 32'd0;
      3'd6: r = (ua < ub) ? 32'd1 : 32'd0;
      default: return {1'b1, {XLEN{1'b0}}};
    endcase
    return {1'b0, r};
  endfunction

  function automatic logic [43:0] exp_vec();
    logic e = (q_res.size() > 0);
    return {e, e ? q_res[0] : 32'd0, e ? q_rd[0] : 5'd0, e ? q_ack[0] : 1'b0,
            m_act, 3'(q_res.size()), (q_res.size() < DEPTH)};
  endfunction

  function automatic logic [43:0] obs_vec();
    return {out_valid, out_result, out_rd, out_reset_ack, activation, count, in_ready};
  endfunction

  task automatic apply(input logic v, input logic [2:0] op, input logic [XLEN-1:0] a,
                       input logic [XLEN-1:0] b, input logic [RDW-1:0] rd,
                       input logic ordy, input logic fl);
    logic m_push, m_pop;
    logic [XLEN:0] r;
    @(negedge clk);
    in_valid = v; in_op = op; in_rs1 = a; in_rs2 = b; in_rd = rd; out_ready = ordy; flush = fl;
    m_push = v && (q_res.size() < DEPTH) && !fl;
    m_pop  = (q_res.size() > 0) && ordy && !fl;
    r = ref_op(op, a, b);
    @(posedge clk);
    if (rst || fl) begin
      q_res.delete(); q_rd.delete(); q_ack.delete();
      m_act = 1'b0;
    end else begin
      if (m_pop) begin
        void'(q_res.pop_front()); void'(q_rd.pop_front()); void'(q_ack.pop_front());
      end
      if (m_push) begin
        q_res.push_back(r[XLEN-1:0]); q_rd.push_back(rd); q_ack.push_back(r[XLEN]);
      end
      m_act = m_pop;
    end
    #1;
  endtask

  task automatic idle(input logic ordy);
    apply(1'b0, 3'd0, 32'd0, 32'd0, 5'd0, ordy, 1'b0);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) begin
      idle(1'b0);
      vectors++;
      if (obs_vec() !== {1'b0, 32'd0, 5'd0, 1'b0, 1'b0, 3'd0, 1'b1}) begin
        miscompares++;
        $display("FAIL reset: got %h want %h", obs_vec(), {1'b0, 32'd0, 5'd0, 1'b0, 1'b0, 3'd0, 1'b1});
      end
    end
    rst = 1'b0;
  endtask

  task automatic test_basic();
    apply(1'b1, 3'd0, 32'd5, 32'd7, 5'd3, 1'b0, 1'b0);
    vectors++;
    if ({out_valid, out_result, out_rd} !== {1'b1, 32'd12, 5'd3}) begin
      miscompares++;
      $display("FAIL basic_add: got %b/%0d/%0d want 1/12/3", out_valid, out_result, out_rd);
    end
    idle(1'b1);
    vectors++;
    if ({activation, out_valid} !== 2'b10) begin
      miscompares++;
      $display("FAIL basic_act: got act=%b vld=%b want act=1 vld=0", activation, out_valid);
    end
    idle(1'b1);
    vectors++;
    if (activation !== 1'b0) begin
      miscompares++;
      $display("FAIL basic_act_end: got %b want 0", activation);
    end
  endtask

  task automatic test_corners();
    logic [2:0]  ops [4] = '{3'd0, 3'd1, 3'd5, 3'd6};
    logic [31:0] as  [4] = '{32'hFFFF_FFFF, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    logic [31:0] bs  [4] = '{32'd1, 32'd1, 32'd1, 32'd1};
    logic [31:0] want[4] = '{32'd0, 32'hFFFF_FFFF, 32'd1, 32'd0};
    for (int i = 0; i < 4; i++) begin
      apply(1'b1, ops[i], as[i], bs[i], 5'(i + 1), 1'b1, 1'b0);
      vectors++;
      if ({out_valid, out_result} !== {1'b1, want[i]}) begin
        miscompares++;
        $display("FAIL corner_%0d: got vld=%b res=%h want vld=1 res=%h", i, out_valid, out_result, want[i]);
      end
    end
    idle(1'b1);
  endtask

  task automatic test_full_wrap();
    for (int fill = 0; fill < 3; fill++) begin
      for (int i = 0; i < DEPTH; i++)
        apply(1'b1, 3'($urandom_range(0, 7)), $urandom, $urandom, 5'($urandom), 1'b0, 1'b0);
      vectors++;
      if ({count, in_ready} !== {3'd4, 1'b0}) begin
        miscompares++;
        $display("FAIL full_%0d: got count=%0d rdy=%b want 4/0", fill, count, in_ready);
      end
      // Fifth op held through a pop while full; it must land only on the following cycle.
      apply(1'b1, 3'd4, 32'hA5A5_0000, 32'h0000_5A5A, 5'd31, 1'b0, 1'b0);
      apply(1'b1, 3'd4, 32'hA5A5_0000, 32'h0000_5A5A, 5'd31, 1'b1, 1'b0);
      vectors++;
      if (obs_vec() !== exp_vec() || count !== 3'd3) begin
        miscompares++;
        $display("FAIL full_pop_%0d: got %h want %h", fill, obs_vec(), exp_vec());
      end
      apply(1'b1, 3'd4, 32'hA5A5_0000, 32'h0000_5A5A, 5'd31, 1'b0, 1'b0);
      for (int i = 0; i < DEPTH + 1; i++) begin
        vectors++;
        if (obs_vec() !== exp_vec()) begin
          miscompares++;
          $display("FAIL drain_%0d_%0d: got %h want %h", fill, i, obs_vec(), exp_vec());
        end
        idle(1'b1);
      end
    end
  endtask

  task automatic test_push_pop();
    apply(1'b1, 3'd2, 32'hF0F0_F0F0, 32'hFF00_FF00, 5'd10, 1'b0, 1'b0);
    apply(1'b1, 3'd3, 32'h0000_00F0, 32'h0000_000F, 5'd11, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      apply(1'b1, 3'd0, $urandom, $urandom, 5'(12 + i), 1'b1, 1'b0);
      vectors++;
      if (obs_vec() !== exp_vec() || count !== 3'd2) begin
        miscompares++;
        $display("FAIL push_pop_%0d: got %h want %h", i, obs_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_flush();
    apply(1'b1, 3'd0, 32'd1, 32'd1, 5'd1, 1'b0, 1'b0);
    vectors++;
    if (count !== 3'd3) begin
      miscompares++;
      $display("FAIL flush_pre: got count=%0d want 3", count);
    end
    apply(1'b1, 3'd0, 32'd9, 32'd9, 5'd9, 1'b1, 1'b1);
    vectors++;
    if ({count, out_valid, activation, out_result} !== {3'd0, 1'b0, 1'b0, 32'd0}) begin
      miscompares++;
      $display("FAIL flush: got cnt=%0d vld=%b act=%b res=%h want 0/0/0/0", count, out_valid, activation, out_result);
    end
    apply(1'b0, 3'd0, 32'd0, 32'd0, 5'd0, 1'b1, 1'b1);
    vectors++;
    if (obs_vec() !== exp_vec()) begin
      miscompares++;
      $display("FAIL flush_empty: got %h want %h", obs_vec(), exp_vec());
    end
  endtask

  task automatic test_rstack_reset();
    apply(1'b1, 3'd7, 32'h55, 32'h0, 5'd9, 1'b0, 1'b0);
    vectors++;
    if ({out_reset_ack, out_result, out_rd} !== {1'b1, 32'd0, 5'd9}) begin
      miscompares++;
      $display("FAIL rstack: got ack=%b res=%h rd=%0d want 1/0/9", out_reset_ack, out_result, out_rd);
    end
    apply(1'b1, 3'd0, 32'd3, 32'd4, 5'd2, 1'b0, 1'b0);
    apply(1'b1, 3'd1, 32'd3, 32'd4, 5'd4, 1'b1, 1'b0);
    rst = 1'b1;
    apply(1'b1, 3'd0, 32'd3, 32'd4, 5'd6, 1'b1, 1'b0);
    rst = 1'b0;
    vectors++;
    if (obs_vec() !== {1'b0, 32'd0, 5'd0, 1'b0, 1'b0, 3'd0, 1'b1}) begin
      miscompares++;
      $display("FAIL rst_mid_drain: got %h want %h", obs_vec(), {1'b0, 32'd0, 5'd0, 1'b0, 1'b0, 3'd0, 1'b1});
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      apply(1'($urandom_range(0, 3) != 0), 3'($urandom_range(0, 7)),
            ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : $urandom,
            ($urandom_range(0, 3) == 0) ? 32'h8000_0000 : $urandom,
            5'($urandom), 1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 31) == 0));
      vectors++;
      if (obs_vec() !== exp_vec()) begin
        miscompares++;
        $display("FAIL random_%0d: got %h want %h", i, obs_vec(), exp_vec());
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_corners();
    test_full_wrap();
    test_push_pop();
    test_flush();
    test_rstack_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
